// File: rtl/fir_pkg.sv
// Shared types, constants and circular-address helper for the FIR MAC sequencer.
package fir_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 21;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_SMP, WRITE, MAC, DRAIN, STORE, OUT
  } seq_state_t;

  // (ptr - k) mod n, valid for any n including non-powers of two
  function automatic int unsigned wrap_dec(input int unsigned ptr,
                                           input int unsigned k,
                                           input int unsigned n);
    return (ptr >= k) ? (ptr - k) : (ptr + n - k);
  endfunction
endpackage

// File: rtl/fir_addr_gen.sv
// Delay-line write pointer and tap counter; derives the circular sample read address.
module fir_addr_gen #(
  parameter int N_TAPS = 8,
  parameter int ADDR_W = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tap_step,
  input  logic              tap_clr,
  input  logic              ptr_clr,
  input  logic              ptr_inc,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] tap_cnt,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tap_last
);
  import fir_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] tap_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      tap_cnt_reg <= '0;
    end else begin
      if (tap_clr)
        tap_cnt_reg <= '0;
      else if (tap_step)
        tap_cnt_reg <= (tap_cnt_reg == LAST) ? '0 : tap_cnt_reg + 1'b1;

      if (ptr_clr)
        wr_ptr_reg <= '0;
      else if (ptr_inc)
        wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  assign wr_ptr   = wr_ptr_reg;
  assign tap_cnt  = tap_cnt_reg;
  assign tap_last = (tap_cnt_reg == LAST);
  assign rd_addr  = ADDR_W'(wrap_dec(32'(wr_ptr_reg), 32'(tap_cnt_reg), 32'(N_TAPS)));
endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the FIR MAC datapath: sample intake, delay-line write, tap sweep,
// accumulator control and result handshake over a programmed block of samples.
module fir_mac_sequencer #(
  parameter int N_TAPS = 8,
  parameter int ADDR_W = $clog2(N_TAPS),
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              START,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_n_samples,
  input  logic              cfg_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sample_in,
  output logic [ADDR_W-1:0] prb_addr,
  output logic              prb_wr_en,
  output logic [DATA_W-1:0] prb_wr_data,
  output logic              prb_rd_en,
  output logic [ADDR_W-1:0] wsp_addr,
  output logic              wsp_rd_en,
  output logic              Acc_en,
  output logic              Acc_zapisz,
  output logic              reset_Acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pracuje,
  output logic              DONE
);
  import fir_pkg::*;

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  n_samples_reg, n_samples_next;
  logic [CNT_W-1:0]  smp_cnt_reg, smp_cnt_next, smp_cnt_inc;
  logic [DATA_W-1:0] sample_reg, sample_next;
  logic              done_reg, done_next;
  logic              tap_step, tap_clr, ptr_clr, ptr_inc, tap_last;
  logic [ADDR_W-1:0] wr_ptr, tap_cnt, rd_addr;

  fir_addr_gen #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .tap_step (tap_step),
    .tap_clr  (tap_clr),
    .ptr_clr  (ptr_clr),
    .ptr_inc  (ptr_inc),
    .wr_ptr   (wr_ptr),
    .tap_cnt  (tap_cnt),
    .rd_addr  (rd_addr),
    .tap_last (tap_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      n_samples_reg <= '0;
      smp_cnt_reg   <= '0;
      sample_reg    <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      n_samples_reg <= n_samples_next;
      smp_cnt_reg   <= smp_cnt_next;
      sample_reg    <= sample_next;
      done_reg      <= done_next;
    end
  end

  assign smp_cnt_inc = smp_cnt_reg + 1'b1;
  assign DONE        = done_reg;
  assign pracuje     = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    n_samples_next = n_samples_reg;
    smp_cnt_next   = smp_cnt_reg;
    sample_next    = sample_reg;
    done_next      = 1'b0;
    tap_step       = 1'b0;
    tap_clr        = 1'b0;
    ptr_clr        = 1'b0;
    ptr_inc        = 1'b0;
    in_ready       = 1'b0;
    prb_addr       = '0;
    prb_wr_en      = 1'b0;
    prb_wr_data    = '0;
    prb_rd_en      = 1'b0;
    wsp_addr       = '0;
    wsp_rd_en      = 1'b0;
    Acc_en         = 1'b0;
    Acc_zapisz     = 1'b0;
    reset_Acc      = 1'b0;
    out_valid      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START) begin
          n_samples_next = cfg_n_samples;
          smp_cnt_next   = '0;
          if (cfg_n_samples == '0)
            done_next = 1'b1;
          else
            state_next = cfg_clear ? CLEAR : WAIT_SMP;
        end
      end
      CLEAR: begin
        prb_wr_en = 1'b1;
        prb_addr  = tap_cnt;
        tap_step  = 1'b1;
        if (tap_last) begin
          ptr_clr    = 1'b1;
          state_next = WAIT_SMP;
        end
      end
      WAIT_SMP: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sample_next = sample_in;
          state_next  = WRITE;
        end
      end
      WRITE: begin
        prb_wr_en   = 1'b1;
        prb_addr    = wr_ptr;
        prb_wr_data = sample_reg;
        reset_Acc   = 1'b1;
        state_next  = MAC;
      end
      MAC: begin
        // accumulator lags the reads by one cycle, so tap 0 has no Acc_en yet
        prb_rd_en = 1'b1;
        wsp_rd_en = 1'b1;
        prb_addr  = rd_addr;
        wsp_addr  = tap_cnt;
        Acc_en    = (tap_cnt != '0);
        tap_step  = 1'b1;
        if (tap_last)
          state_next = DRAIN;
      end
      DRAIN: begin
        Acc_en     = 1'b1;
        state_next = STORE;
      end
      STORE: begin
        Acc_zapisz = 1'b1;
        ptr_inc    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          smp_cnt_next = smp_cnt_inc;
          if (smp_cnt_inc == n_samples_reg) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_SMP;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // abort wins over START and both handshakes; pointer and delay line are kept
    if (abort) begin
      state_next     = IDLE;
      n_samples_next = n_samples_reg;
      smp_cnt_next   = smp_cnt_reg;
      sample_next    = sample_reg;
      done_next      = 1'b0;
      tap_step       = 1'b0;
      tap_clr        = 1'b1;
      ptr_clr        = 1'b0;
      ptr_inc        = 1'b0;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      prb_wr_en      = 1'b0;
    end
  end
endmodule
